// File: rtl/udp_axis_pkt_gen_if.sv
// AXI-Stream bundle for the UDP TX payload path.
//   master : tvalid/tdata/tkeep/tlast/tuser out, tready in  (packet generator)
//   slave  : the mirror image                               (downstream TX buffer)
interface udp_axis_pkt_gen_if #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = 64,
  parameter int TUSER_WIDTH = 1
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/udp_axis_pkt_gen.sv
// Synthetic UDP payload source for the 512-bit AXIS TX path (XDMA clock domain).
// Emits pkt_num fixed-size packets (0 = until stop) separated by pkt_interval
// idle cycles. Beat b of packet p carries lane i = {p[15:0], b[11:0], i[3:0]}.
// Ports:
//   xdma_clk, xdma_reset       clock, synchronous active-high reset
//   start, stop                run launch pulse / end-after-current-packet level
//   pkt_size/interval/num      run configuration, sampled on an accepted start
//   udp_tx_axis (master)       AXIS output, all fields registered, tuser = 0
//   busy, size_err             run in progress / sticky zero-size start
//   sent_pkt_count/beat_count  handshaked packets/beats of the current run
// Optional macro UDP_PKT_GEN_TIMESTAMP_EN: lane 15 of each first beat carries a
// free-running cycle counter captured when that beat is loaded.
module udp_axis_pkt_gen #(
  parameter int TDATA_WIDTH = 512,
  parameter int TKEEP_WIDTH = 64,
  parameter int TUSER_WIDTH = 1
) (
  input  logic               xdma_clk,
  input  logic               xdma_reset,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        pkt_size,
  input  logic [31:0]        pkt_interval,
  input  logic [31:0]        pkt_num,
  udp_axis_pkt_gen_if.master udp_tx_axis,
  output logic               busy,
  output logic               size_err,
  output logic [31:0]        sent_pkt_count,
  output logic [31:0]        sent_beat_count
);
  localparam int NUM_LANES = TDATA_WIDTH / 32;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;

  logic [15:0] size_q, seq_q, ld_seq, cfg_size;
  logic [31:0] interval_q, num_q, gap_cnt;
  logic [11:0] beat_q, ld_beat;
  logic [10:0] nbeats;
  logic [5:0]  rem;
  logic [TKEEP_WIDTH-1:0] keep_last;
  logic        ld_last, load, hs, done, cfg_ok;

  logic                   tvalid_q, tlast_q;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [TKEEP_WIDTH-1:0] tkeep_q;
  logic [NUM_LANES-1:0][31:0] pat;

  logic unused_bits;
  assign unused_bits = ^pkt_size[31:16];

  assign hs     = tvalid_q & udp_tx_axis.tready;
  assign cfg_ok = start & ~stop & (pkt_size[15:0] != 16'd0);
  assign done   = ((num_q != 32'd0) && (sent_pkt_count + 32'd1 == num_q)) || stop;

  // Next-state plus "load a beat into the output register" decision.
  always_comb begin
    state_n  = state;
    load     = 1'b0;
    ld_seq   = seq_q;
    ld_beat  = 12'd0;
    cfg_size = size_q;
    case (state)
      IDLE: begin
        // First beat is built from the live inputs so it appears at T+1.
        cfg_size = pkt_size[15:0];
        if (cfg_ok) begin
          state_n = SEND;
          load    = 1'b1;
          ld_seq  = 16'd0;
        end
      end
      SEND: begin
        if (hs) begin
          if (!tlast_q) begin
            load    = 1'b1;
            ld_beat = beat_q + 12'd1;
          end else if (done) begin
            state_n = IDLE;
          end else if (interval_q != 32'd0) begin
            state_n = GAP;
          end else begin
            load   = 1'b1;
            ld_seq = seq_q + 16'd1;
          end
        end
      end
      GAP: begin
        // gap_cnt holds N on the first idle cycle, so 1 means the Nth.
        if (stop) begin
          state_n = IDLE;
        end else if (gap_cnt == 32'd1) begin
          state_n = SEND;
          load    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rem       = cfg_size[5:0];
  assign nbeats    = {1'b0, cfg_size[15:6]} + {10'd0, |rem};
  assign ld_last   = (ld_beat == ({1'b0, nbeats} - 12'd1));
  assign keep_last = (rem == 6'd0) ? {TKEEP_WIDTH{1'b1}}
                                   : ((TKEEP_WIDTH'(1) << rem) - TKEEP_WIDTH'(1));

`ifdef UDP_PKT_GEN_TIMESTAMP_EN
  logic [31:0] ts_q;
  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) ts_q <= 32'd0;
    else            ts_q <= ts_q + 32'd1;
  end
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
`ifdef UDP_PKT_GEN_TIMESTAMP_EN
    if (g == NUM_LANES - 1) begin : g_ts
      assign pat[g] = (ld_beat == 12'd0) ? ts_q : {ld_seq, ld_beat, 4'(g)};
    end else begin : g_pat
      assign pat[g] = {ld_seq, ld_beat, 4'(g)};
    end
`else
    assign pat[g] = {ld_seq, ld_beat, 4'(g)};
`endif
  end

  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) state <= IDLE;
    else            state <= state_n;
  end

  always_ff @(posedge xdma_clk) begin
    if (xdma_reset) begin
      size_q          <= '0;
      interval_q      <= '0;
      num_q           <= '0;
      seq_q           <= '0;
      beat_q          <= '0;
      gap_cnt         <= '0;
      tvalid_q        <= 1'b0;
      tdata_q         <= '0;
      tkeep_q         <= '0;
      tlast_q         <= 1'b0;
      busy            <= 1'b0;
      size_err        <= 1'b0;
      sent_pkt_count  <= '0;
      sent_beat_count <= '0;
    end else begin
      busy <= (state_n != IDLE);

      if (state == IDLE && start) begin
        if (pkt_size[15:0] == 16'd0) begin
          size_err <= 1'b1;
        end else if (!stop) begin
          size_q          <= pkt_size[15:0];
          interval_q      <= pkt_interval;
          num_q           <= pkt_num;
          seq_q           <= 16'd0;
          size_err        <= 1'b0;
          sent_pkt_count  <= '0;
          sent_beat_count <= '0;
        end
      end

      if (hs) begin
        sent_beat_count <= sent_beat_count + 32'd1;
        if (tlast_q) begin
          sent_pkt_count <= sent_pkt_count + 32'd1;
          seq_q          <= seq_q + 16'd1;
        end
      end

      if (state == SEND && hs && tlast_q) gap_cnt <= interval_q;
      else if (state == GAP)              gap_cnt <= gap_cnt - 32'd1;

      if (load) begin
        tvalid_q <= 1'b1;
        tdata_q  <= pat;
        tkeep_q  <= ld_last ? keep_last : {TKEEP_WIDTH{1'b1}};
        tlast_q  <= ld_last;
        beat_q   <= ld_beat;
      end else if (hs) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign udp_tx_axis.tvalid = tvalid_q;
  assign udp_tx_axis.tdata  = tdata_q;
  assign udp_tx_axis.tkeep  = tkeep_q;
  assign udp_tx_axis.tlast  = tlast_q;
  assign udp_tx_axis.tuser  = '0;
endmodule

// File: tb/tb_udp_axis_pkt_gen.sv
module tb_udp_axis_pkt_gen;
  logic        xdma_clk = 1'b0;
  logic        xdma_reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0;
  logic [31:0] pkt_size = '0, pkt_interval = '0, pkt_num = '0;
  logic        busy, size_err;
  logic [31:0] sent_pkt_count, sent_beat_count;

  always #5 xdma_clk = ~xdma_clk;

  udp_axis_pkt_gen_if #(.TDATA_WIDTH(512), .TKEEP_WIDTH(64), .TUSER_WIDTH(1)) axis ();

  udp_axis_pkt_gen #(.TDATA_WIDTH(512), .TKEEP_WIDTH(64), .TUSER_WIDTH(1)) dut (
    .xdma_clk        (xdma_clk),
    .xdma_reset      (xdma_reset),
    .start           (start),
    .stop            (stop),
    .pkt_size        (pkt_size),
    .pkt_interval    (pkt_interval),
    .pkt_num         (pkt_num),
    .udp_tx_axis     (axis),
    .busy            (busy),
    .size_err        (size_err),
    .sent_pkt_count  (sent_pkt_count),
    .sent_beat_count (sent_beat_count)
  );

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } beat_t;

  int    checks = 0, failures = 0;
  beat_t exp_q[$], got_q[$];
  int    gaps[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge xdma_clk);
    #1;
  endtask

  // Reference: every packet is ceil(size/64) beats, lanes numbered by formula.
  function automatic void build(input int size, input int npkts);
    int    nb, rem;
    beat_t e;
    exp_q.delete();
    nb  = (size + 63) / 64;
    rem = size % 64;
    for (int p = 0; p < npkts; p++)
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 16; i++)
          e.data[i*32 +: 32] = 32'((p % 65536) * 65536 + (b % 4096) * 16 + i);
        e.last = (b == nb - 1);
        e.keep = (e.last && rem != 0) ? ((64'd1 << rem) - 64'd1) : {64{1'b1}};
        exp_q.push_back(e);
      end
  endfunction

  // Launch a run, collect handshaked beats and idle gaps, compare with model.
  task automatic run(input int size, input int interval, input int num,
                     input int rdy_pct, input int stop_pkt);
    int    npkts, idle;
    bit    in_gap, prev_stall, finished, rdy, first;
    beat_t prev, cur, e;
    npkts = (num == 0) ? stop_pkt + 1 : num;
    build(size, npkts);
    got_q.delete();
    gaps.delete();
    idle = 0; in_gap = 0; prev_stall = 0; finished = 0;
    prev = '0;

    pkt_size = 32'(size); pkt_interval = 32'(interval); pkt_num = 32'(num);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("first_valid", axis.tvalid, 1'b1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy && !axis.tvalid) begin
        finished = 1;
        break;
      end
      cur.data = axis.tdata; cur.keep = axis.tkeep; cur.last = axis.tlast;
      if (prev_stall) begin
        chk("hold_valid", axis.tvalid, 1'b1);
        chk("hold_beat", cur, prev);
      end
      if (axis.tvalid) begin
        if (in_gap) gaps.push_back(idle);
        in_gap = 0;
        idle   = 0;
      end else if (in_gap) begin
        idle++;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      axis.tready = rdy;
      if (num == 0 && axis.tvalid &&
          axis.tdata[31:0] == 32'((stop_pkt % 65536) * 65536 + 16))
        stop = 1'b1;
      if (axis.tvalid && rdy) begin
        got_q.push_back(cur);
        if (cur.last) in_gap = 1;
      end
      prev_stall = axis.tvalid && !rdy;
      prev       = cur;
      step();
    end
    stop = 1'b0;
    chk("run_finished", finished, 1'b1);

    chk("beat_total", got_q.size(), exp_q.size());
    first = 1;
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      e = exp_q[k];
`ifdef UDP_PKT_GEN_TIMESTAMP_EN
      if (first) e.data[511:480] = got_q[k].data[511:480];
`endif
      chk($sformatf("data[%0d]", k), got_q[k].data, e.data);
      chk($sformatf("keep[%0d]", k), got_q[k].keep, e.keep);
      chk($sformatf("last[%0d]", k), got_q[k].last, e.last);
      first = e.last;
    end
    chk("gap_total", gaps.size(), npkts - 1);
    foreach (gaps[k]) chk($sformatf("gap_len[%0d]", k), gaps[k], interval);
    chk("pkt_count", sent_pkt_count, npkts);
    chk("beat_count", sent_beat_count, exp_q.size());
    chk("busy_end", busy, 1'b0);
    chk("size_err_clear", size_err, 1'b0);
  endtask

  initial begin
    axis.tready = 1'b0;
    step(); step();
    chk("rst_tvalid", axis.tvalid, 1'b0);
    chk("rst_tdata", axis.tdata, '0);
    chk("rst_tkeep", axis.tkeep, '0);
    chk("rst_tlast", axis.tlast, 1'b0);
    chk("rst_tuser", axis.tuser, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_size_err", size_err, 1'b0);
    chk("rst_pkt_cnt", sent_pkt_count, 32'd0);
    chk("rst_beat_cnt", sent_beat_count, 32'd0);
    xdma_reset = 1'b0;
    step();

    // Single-beat packets back to back.
    run(64, 0, 4, 100, -1);

    // Three-beat packet with a 2-byte tail.
    run(130, 0, 1, 100, -1);
    chk("tail_lane1", got_q[2].data[63:32], 32'h00000021);
    chk("tail_keep", got_q[2].keep, 64'h3);

    // Inter-packet gap of 5.
    run(128, 5, 2, 100, -1);

    // Backpressure at 50%.
    run(256, 0, 3, 50, -1);

    // Randomized configurations.
    for (int r = 0; r < 4; r++)
      run($urandom_range(300, 1), $urandom_range(3), $urandom_range(4, 1),
          $urandom_range(100, 30), -1);

    // Continuous mode, stop during beat 1 of packet 7.
    run(200, 1, 0, 100, 7);

    // Zero-size start flags an error and does not launch.
    pkt_size = 32'd0; pkt_num = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_size_err", size_err, 1'b1);
    chk("zero_size_busy", busy, 1'b0);
    chk("zero_size_valid", axis.tvalid, 1'b0);
    step();
    chk("zero_size_busy2", busy, 1'b0);

    // Start together with stop is ignored.
    pkt_size = 32'd64;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 1'b0);
    chk("start_stop_valid", axis.tvalid, 1'b0);
    chk("start_stop_err", size_err, 1'b1);

    // Reset in the middle of a long packet.
    pkt_size = 32'd640; pkt_interval = 32'd0; pkt_num = 32'd1;
    axis.tready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    chk("pre_rst_valid", axis.tvalid, 1'b1);
    chk("pre_rst_beats", sent_beat_count, 32'd2);
    xdma_reset = 1'b1;
    step();
    chk("mid_rst_valid", axis.tvalid, 1'b0);
    chk("mid_rst_tdata", axis.tdata, '0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pkt_cnt", sent_pkt_count, 32'd0);
    chk("mid_rst_beat_cnt", sent_beat_count, 32'd0);
    xdma_reset = 1'b0;
    step();
    run(64, 0, 1, 100, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/udp_axis_pkt_gen.md
# udp_axis_pkt_gen

Synthetic UDP payload source that drives the 512-bit AXI-Stream TX input of the UDP/CMAC transmit path, upstream of the cross-die TX buffer, in the XDMA clock domain. It emits a configurable number of fixed-size packets with a programmable inter-packet gap and a deterministic, checkable data pattern. It also reports sent packet and beat counts to the performance monitor.

## Interface
Parameters:
- `TDATA_WIDTH`, 512, AXIS data width; fixed, only 512 supported.
- `TKEEP_WIDTH`, 64, AXIS keep width.
- `TUSER_WIDTH`, 1, AXIS user width.

Ports:
- `xdma_clk`  in  1  sole clock.
- `xdma_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that launches a run; ignored while busy.
- `stop`  in  1  level; ends the run after the current packet.
- `pkt_size`  in  32  packet bytes, sampled at start; only bits [15:0] are used.
- `pkt_interval`  in  32  idle cycles between packets, sampled at start.
- `pkt_num`  in  32  packets per run, sampled at start; 0 = continuous until stop.
- `udp_tx_axis_tvalid/tdata/tkeep/tlast/tuser`  out  1/512/64/1/1  AXIS master; tuser is constant 0.
- `udp_tx_axis_tready`  in  1  AXIS ready.
- `busy`  out  1  run in progress.
- `size_err`  out  1  sticky: start seen with pkt_size[15:0]==0; cleared by the next valid start.
- `sent_pkt_count`  out  32  handshaked tlast beats in the current run.
- `sent_beat_count`  out  32  handshaked beats in the current run.

## Operation
- States: IDLE, SEND, GAP.
  - **IDLE:** A start with size≠0 and stop=0 latches the configuration, clears both counters and size_err, then moves to SEND. If start arrives with size==0, set size_err and stay in IDLE. If start and stop arrive in the same cycle, stay in IDLE.
  - **SEND:** Present beats in order. The last beat handshake increments sent_pkt_count and the packet sequence number. The run is done when pkt_num≠0 and sent_pkt_count reaches pkt_num, or when stop is high at the last handshake; either way, go to IDLE. Otherwise go to GAP if interval≠0, or start the next packet in SEND if interval==0.
  - **GAP:** Count pkt_interval cycles, then return to SEND. If stop is high during GAP, go to IDLE.
- Stop never truncates a packet.
- Beats per packet = ceil(size/64).
  - Non-last beats have tkeep all ones.
  - The last beat has tkeep with the low (size mod 64) bits set, or all ones if the remainder is 0.
  - tlast is set only on the last beat.
- Data pattern: in beat b of packet p, 32-bit lane i (i=0..15, lane 0 at bits [31:0]) = {p[15:0], b[11:0], i[3:0]}. p starts at 0 on each start. Lanes beyond the valid bytes follow the same pattern.
- Counters wrap modulo 2^32 and hold their values in IDLE.
- busy = (state≠IDLE).

## Timing
- All outputs are registered.
- Reset values: tvalid 0, tdata 0, tkeep 0, tlast 0, busy 0, size_err 0, both counters 0, state IDLE.
- A start sampled at cycle T produces the first beat with tvalid=1 at T+1.
- AXIS rules:
  - Once tvalid=1, tvalid, tdata, tkeep and tlast stay stable until the cycle with tready=1.
  - tvalid never depends combinationally on tready.
  - A new beat may be presented in the cycle after a handshake.
- Interval 0: packets are back-to-back, so tvalid can stay high continuously at full rate.
- Interval N>0: exactly N cycles with tvalid=0 between the last-beat handshake and the next first beat.
- Counters update in the cycle after the handshake that triggers them.
- Reset mid-packet: all outputs return to reset values in the next cycle. No packet completion is attempted.

## Configuration
- `UDP_PKT_GEN_TIMESTAMP_EN`:
  - **Defined:** A free-running 32-bit cycle counter (reset to 0, increments every cycle, wraps) replaces lane 15 of the first beat of each packet. Its value is captured when that beat is first presented and held stable until the handshake.
  - **Undefined:** No counter exists; lane 15 carries the normal pattern.

## Test plan
- size=64, interval=0, num=4, tready=1 → 4 consecutive beats, each with tlast=1 and tkeep=all ones, lane0 = 0x00000000, 0x00010000, 0x00020000, 0x00030000. Then sent_pkt_count=4, sent_beat_count=4, busy=0.
- size=130, num=1 → 3 beats; tlast only on beat 2, whose tkeep=0x3; beat 2 lane 1 = 0x00000021.
- size=128, interval=5, num=2 → exactly 5 cycles with tvalid=0 between the first packet's tlast handshake and the second packet's first beat.
- size=256, num=3, tready random at 50% → beats held stable while stalled, no duplicate or missing beats, sent_beat_count=12.
- num=0, stop raised during the 2nd beat of packet 7 → packet 7 completes all its beats and no further packet starts; start with size=0 → size_err=1 and busy stays 0.
- Reset asserted mid-packet → tvalid=0, counters=0, busy=0 on the next cycle. A start afterwards restarts at sequence 0.
